fetch_unit: RTL and testbench

Instruction fetch front end that sits upstream of the single-cycle core's decode/execute datapath. It generates sequential PCs and issues them to a pipelined instruction memory over a valid/ready request channel. It buffers returned instructions together with their PCs in a small FIFO and presents them downstream over a valid/ready handshake. It also accepts redirects (branch/jump targets), flushing queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_unit_if.sv | 41 ++++
 rtl/fetch_queue.sv | 94 +++++++++
 rtl/fetch_unit_chk.sv | 19 +
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction fetch front end.
//   XLEN         - default instruction / address width
//   RESET_PC_DEF - default first fetch address after reset
//   PC_INC       - byte distance between sequential instruction words
package fetch_pkg;

   localparam int unsigned     XLEN         = 32'd32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned     PC_INC       = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the imem request/response channel, the downstream
// instruction handshake and the redirect input of the fetch unit.
//   master : the fetch unit side (drives requests and instructions)
//   slave  : the environment side (imem, consumer, branch resolution)
interface fetch_unit_if
   import fetch_pkg::*;
#(
   parameter int DWIDTH = XLEN
);

   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [DWIDTH-1:0] imem_req_addr;
   logic              imem_resp_valid;
   logic [DWIDTH-1:0] imem_resp_data;
   logic              instr_valid;
   logic              instr_ready;
   logic [DWIDTH-1:0] instr_data;
   logic [DWIDTH-1:0] instr_pc;
   logic              redirect_valid;
   logic [DWIDTH-1:0] redirect_pc;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid, imem_resp_data,
      output instr_valid, instr_data, instr_pc,
      input  instr_ready,
      input  redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid, imem_resp_data,
      input  instr_valid, instr_data, instr_pc,
      output instr_ready,
      output redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {instruction, pc} pairs with flush and a
// registered head, so a pushed entry becomes visible one cycle later.
//   clk, rst            - clock, asynchronous active-low reset
//   flush               - empty the queue (wins over push/pop)
//   push, push_data/pc  - write one entry (caller guarantees no overflow)
//   pop                 - consume the head; ignored while empty
//   count               - number of stored entries, head included
//   head_valid/data/pc  - registered head of the queue
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DWIDTH = XLEN,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [DWIDTH-1:0]          push_data,
   input  logic [DWIDTH-1:0]          push_pc,
   input  logic                       pop,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       head_valid,
   output logic [DWIDTH-1:0]          head_data,
   output logic [DWIDTH-1:0]          head_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DWIDTH-1:0] data_mem_r [DEPTH];
   logic [DWIDTH-1:0] pc_mem_r   [DEPTH];
   logic [PW-1:0]     rd_ptr_r;
   logic [PW-1:0]     wr_ptr_r;
   logic [CW-1:0]     count_r;
   logic              head_valid_r;
   logic [DWIDTH-1:0] head_data_r;
   logic [DWIDTH-1:0] head_pc_r;

   logic              do_pop_s;
   logic [PW-1:0]     rd_next_s;
   logic [CW-1:0]     count_next_s;
   logic              head_from_push_s;

   // Next-state pointer/count and head source selection.
   always_comb begin
      do_pop_s     = pop && head_valid_r;
      rd_next_s    = do_pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
      count_next_s = count_r + CW'(push) - CW'(do_pop_s);
      // The pushed word becomes the head when nothing else remains in
      // front of it; the array write has not landed yet, so bypass it.
      head_from_push_s = push && ((count_r - CW'(do_pop_s)) == {CW{1'b0}});
   end

   // Storage, pointers and registered head.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem_r[i] <= {DWIDTH{1'b0}};
            pc_mem_r[i]   <= {DWIDTH{1'b0}};
         end
         rd_ptr_r     <= {PW{1'b0}};
         wr_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         head_valid_r <= 1'b0;
         head_data_r  <= {DWIDTH{1'b0}};
         head_pc_r    <= {DWIDTH{1'b0}};
      end else if (flush) begin
         rd_ptr_r     <= {PW{1'b0}};
         wr_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         head_valid_r <= 1'b0;
      end else begin
         if (push) begin
            data_mem_r[wr_ptr_r] <= push_data;
            pc_mem_r[wr_ptr_r]   <= push_pc;
            wr_ptr_r             <= wr_ptr_r + PW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         rd_ptr_r     <= rd_next_s;
         count_r      <= count_next_s;
         head_valid_r <= (count_next_s != {CW{1'b0}});
         head_data_r  <= head_from_push_s ? push_data : data_mem_r[rd_next_s];
         head_pc_r    <= head_from_push_s ? push_pc   : pc_mem_r[rd_next_s];
      end
   end

   assign count      = count_r;
   assign head_valid = head_valid_r;
   assign head_data  = head_data_r;
   assign head_pc    = head_pc_r;

endmodule

// File: rtl/fetch_unit_chk.sv
// fetch_unit_chk: protocol checks for the fetch unit's imem interface.
//   clk, rst   - clock, asynchronous active-low reset
//   resp_valid - imem response strobe
//   inflight   - outstanding request count inside the fetch unit
module fetch_unit_chk #(
   parameter int CW = 3
) (
   input logic          clk,
   input logic          rst,
   input logic          resp_valid,
   input logic [CW-1:0] inflight
);

   // Every response must match a previously accepted request.
   a_resp_has_request: assert property (
      @(posedge clk) disable iff (!rst) resp_valid |-> (inflight != {CW{1'b0}})
   );

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Issues sequential word addresses to
// a pipelined imem, queues returned words with their PCs and hands them to the
// core over a valid/ready handshake. A redirect restarts the stream, flushing
// queued words and discarding responses still in flight.
//   clk - system clock, rising edge
//   rst - asynchronous active-low reset
//   bus - fetch_unit_if.master: imem request/response, instr out, redirect in
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                DWIDTH   = XLEN,
   parameter int                DEPTH    = 4,
   parameter logic [DWIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   localparam int                CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]       DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(PC_INC);

   logic [DWIDTH-1:0] fetch_pc_r;
   logic [DWIDTH-1:0] resp_pc_r;
   logic [CW-1:0]     inflight_r;
   logic [CW-1:0]     drop_cnt_r;

   logic [CW-1:0]     q_count_s;
   logic [CW:0]       credit_sum_s;
   logic              req_valid_s;
   logic              accept_s;
   logic              resp_ok_s;
   logic              push_s;
   logic [CW-1:0]     inflight_next_s;
   logic [DWIDTH-1:0] redirect_target_s;

   // Credit check, handshake qualification and in-flight accounting.
   always_comb begin
      credit_sum_s = {1'b0, q_count_s} + {1'b0, inflight_r};
      // Gated by rst so the request drops the moment reset asserts.
      req_valid_s  = rst && !bus.redirect_valid && (credit_sum_s < DEPTH_W);
      accept_s     = req_valid_s && bus.imem_req_ready;
      // A response with nothing outstanding is ignored.
      resp_ok_s    = bus.imem_resp_valid && (inflight_r != {CW{1'b0}});
      // Stale responses are dropped, including one arriving with a redirect.
      push_s       = resp_ok_s && (drop_cnt_r == {CW{1'b0}}) && !bus.redirect_valid;
      inflight_next_s   = inflight_r + CW'(accept_s) - CW'(resp_ok_s);
      redirect_target_s = {bus.redirect_pc[DWIDTH-1:2], 2'b00};
   end

   // Fetch/response PCs, in-flight and drop counters; redirect has priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_r <= RESET_PC;
         resp_pc_r  <= RESET_PC;
         inflight_r <= {CW{1'b0}};
         drop_cnt_r <= {CW{1'b0}};
      end else begin
         inflight_r <= inflight_next_s;
         if (bus.redirect_valid) begin
            fetch_pc_r <= redirect_target_s;
            resp_pc_r  <= redirect_target_s;
            // Everything still outstanding after this cycle is stale.
            drop_cnt_r <= inflight_next_s;
         end else begin
            fetch_pc_r <= accept_s ? (fetch_pc_r + PC_STEP) : fetch_pc_r;
            if (resp_ok_s && (drop_cnt_r != {CW{1'b0}})) begin
               drop_cnt_r <= drop_cnt_r - CW'(1);
               resp_pc_r  <= resp_pc_r;
            end else if (resp_ok_s) begin
               drop_cnt_r <= drop_cnt_r;
               resp_pc_r  <= resp_pc_r + PC_STEP;
            end else begin
               drop_cnt_r <= drop_cnt_r;
               resp_pc_r  <= resp_pc_r;
            end
         end
      end
   end

   assign bus.imem_req_valid = req_valid_s;
   assign bus.imem_req_addr  = fetch_pc_r;

   fetch_queue #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.redirect_valid),
      .push       (push_s),
      .push_data  (bus.imem_resp_data),
      .push_pc    (resp_pc_r),
      .pop        (bus.instr_ready),
      .count      (q_count_s),
      .head_valid (bus.instr_valid),
      .head_data  (bus.instr_data),
      .head_pc    (bus.instr_pc)
   );

   fetch_unit_chk #(
      .CW (CW)
   ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .resp_valid (bus.imem_resp_valid),
      .inflight   (inflight_r)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-configurable imem
// model (mem[i] = 0xA000_0000 + i, i = word index).
module tb_fetch_unit;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic        irdy;
      logic        rv;
      logic [31:0] addr;
      logic        iv;
      logic [31:0] pc;
   } vec_t;

   logic clk;
   logic rst;

   int          total;
   int          bad;
   int          cyc;
   int          lat;
   pend_t       pend[$];
   vec_t        vecs[$];
   logic [31:0] got[$];

   fetch_unit_if #(.DWIDTH(32)) bus ();

   fetch_unit #(
      .DWIDTH   (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'hA000_0000 + (addr >> 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge: sample handshakes, cross the edge, update imem model.
   task automatic advance();
      logic        acc;
      logic [31:0] a;
      logic        fire;
      acc  = bus.imem_req_valid && bus.imem_req_ready;
      a    = bus.imem_req_addr;
      fire = bus.imem_resp_valid;
      if (bus.instr_valid && bus.instr_ready) got.push_back(bus.instr_pc);
      @(posedge clk);
      #1;
      if (fire && (pend.size() > 0)) pend.delete(0);
      if (acc) pend.push_back('{addr: a, due: cyc + lat});
      cyc++;
      if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = mem_word(pend[0].addr);
      end else begin
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = 32'h0;
      end
   endtask

   // Bounded wait for a valid head; returns at a negedge.
   task automatic wait_valid(input string name, output int waited);
      waited = 0;
      @(negedge clk);
      while (!bus.instr_valid && (waited < 20)) begin
         advance();
         waited++;
         @(negedge clk);
      end
      if (!bus.instr_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic do_reset(input int latency);
      rst                 = 1'b0;
      lat                 = latency;
      bus.imem_req_ready  = 1'b1;
      bus.instr_ready     = 1'b1;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 32'h0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      pend.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0;
      got.delete();
   endtask

   task automatic run_vecs(input string name, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         bus.instr_ready = vecs[i].irdy;
         @(negedge clk);
         chk($sformatf("%s_rv[%0d]", name, i - first), 32'(bus.imem_req_valid), 32'(vecs[i].rv));
         if (vecs[i].rv) chk($sformatf("%s_addr[%0d]", name, i - first), bus.imem_req_addr, vecs[i].addr);
         chk($sformatf("%s_iv[%0d]", name, i - first), 32'(bus.instr_valid), 32'(vecs[i].iv));
         if (vecs[i].iv) begin
            chk($sformatf("%s_pc[%0d]", name, i - first), bus.instr_pc, vecs[i].pc);
            chk($sformatf("%s_data[%0d]", name, i - first), bus.instr_data, mem_word(vecs[i].pc));
         end
         advance();
      end
   endtask

   initial begin
      int          n;
      logic [31:0] rdy_pat [8];
      logic [31:0] addr_pat [8];
      total = 0;
      bad   = 0;
      cyc   = 0;

      // Test 1 table: free-flowing stream, latency 1 (rows 0..9).
      for (int k = 0; k < 10; k++)
         vecs.push_back('{irdy: 1'b1, rv: 1'b1, addr: 32'(4 * k),
                          iv: (k >= 2), pc: 32'(4 * (k - 2))});
      // Test 2 table: consumer stalled 10 cycles, then released (rows 10..25).
      for (int k = 0; k < 10; k++)
         vecs.push_back('{irdy: 1'b0, rv: (k < 4), addr: 32'(4 * k),
                          iv: (k >= 2), pc: 32'h0});
      vecs.push_back('{irdy: 1'b1, rv: 1'b0, addr: 32'h0, iv: 1'b1, pc: 32'h0});
      for (int k = 11; k < 16; k++)
         vecs.push_back('{irdy: 1'b1, rv: 1'b1, addr: 32'(16 + 4 * (k - 11)),
                          iv: 1'b1, pc: 32'(4 * (k - 10))});

      // Reset state, checked before any clock edge.
      rst                 = 1'b1;
      bus.imem_req_ready  = 1'b1;
      bus.instr_ready     = 1'b1;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 32'h0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      #1 rst = 1'b0;
      #2;
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr_pc", bus.instr_pc, 32'h0);
      chk("rst_instr_data", bus.instr_data, 32'h0);

      do_reset(1);
      run_vecs("t1", 0, 9);

      do_reset(1);
      run_vecs("t2", 10, 25);

      // Test 3: latency 3, redirect with two requests outstanding.
      do_reset(3);
      @(negedge clk); advance();
      @(negedge clk); advance();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0100;
      @(negedge clk);
      chk("t3_rv_in_redirect", 32'(bus.imem_req_valid), 32'd0);
      advance();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("t3_rv_after", 32'(bus.imem_req_valid), 32'd1);
      chk("t3_addr_after", bus.imem_req_addr, 32'h0000_0100);
      chk("t3_iv_after", 32'(bus.instr_valid), 32'd0);
      advance();
      wait_valid("t3", n);
      chk("t3_wait", 32'(n), 32'd3);
      chk("t3_pc", bus.instr_pc, 32'h0000_0100);
      chk("t3_data", bus.instr_data, 32'hA000_0040);
      advance();
      @(negedge clk);
      chk("t3_pc2", bus.instr_pc, 32'h0000_0104);
      advance();

      // Test 4: unaligned redirect mid-stream, then back-to-back redirects.
      do_reset(1);
      repeat (4) begin
         @(negedge clk);
         advance();
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0103;
      @(negedge clk);
      chk("t4_rv_in_redirect", 32'(bus.imem_req_valid), 32'd0);
      advance();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("t4_addr_after", bus.imem_req_addr, 32'h0000_0100);
      chk("t4_iv_after", 32'(bus.instr_valid), 32'd0);
      advance();
      wait_valid("t4", n);
      chk("t4_wait", 32'(n), 32'd1);
      chk("t4_pc", bus.instr_pc, 32'h0000_0100);
      advance();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0200;
      @(negedge clk);
      advance();
      bus.redirect_pc    = 32'h0000_0300;
      @(negedge clk);
      chk("t4b_iv_flushed", 32'(bus.instr_valid), 32'd0);
      advance();
      bus.redirect_valid = 1'b0;
      wait_valid("t4b", n);
      chk("t4b_pc", bus.instr_pc, 32'h0000_0300);
      chk("t4b_data", bus.instr_data, 32'hA000_00C0);
      advance();

      // Test 5: imem_req_ready toggling holds the address stable.
      do_reset(1);
      rdy_pat  = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
      addr_pat = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
      for (int i = 0; i < 8; i++) begin
         bus.imem_req_ready = rdy_pat[i][0];
         @(negedge clk);
         chk($sformatf("t5_rv[%0d]", i), 32'(bus.imem_req_valid), 32'd1);
         chk($sformatf("t5_addr[%0d]", i), bus.imem_req_addr, addr_pat[i]);
         advance();
      end
      chk("t5_delivered", 32'(got.size()), 32'd4);
      for (int i = 0; i < got.size(); i++)
         chk($sformatf("t5_got[%0d]", i), got[i], 32'(4 * i));

      // Test 6: asynchronous reset with three entries queued.
      do_reset(1);
      bus.instr_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         advance();
      end
      chk("t6_iv_before", 32'(bus.instr_valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("t6_iv_async", 32'(bus.instr_valid), 32'd0);
      chk("t6_rv_async", 32'(bus.imem_req_valid), 32'd0);
      chk("t6_pc_async", bus.instr_pc, 32'h0);
      chk("t6_data_async", bus.instr_data, 32'h0);
      do_reset(1);
      @(negedge clk);
      chk("t6_rv_restart", 32'(bus.imem_req_valid), 32'd1);
      chk("t6_addr_restart", bus.imem_req_addr, 32'h0);
      advance();
      wait_valid("t6", n);
      chk("t6_pc_restart", bus.instr_pc, 32'h0);
      chk("t6_data_restart", bus.instr_data, 32'hA000_0000);
      advance();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
